reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count (power of two, >=4); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter TAP_IDX, default 13, register index mirrored on the debug tap.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 clr_req  in  1  soft request to re-zero all registers.
REQ-008 ready  out  1  high when the file accepts writes and reads return register data.
REQ-009 we  in  1  write enable.
REQ-010 rd  in  AW  write address.
REQ-011 wdata  in  XLEN  write data.
REQ-012 alloc_v  in  1  marks a register as pending, i.e. issued but not yet written back.
REQ-013 alloc_rd  in  AW  register to mark pending.
REQ-014 rs  in  NRD x AW  read addresses.
REQ-015 rdata  out  NRD x XLEN  read data.
REQ-016 rs_pend  out  NRD  pending flag per read port.
REQ-017 tap  out  XLEN  registered copy of register TAP_IDX.

Function
REQ-018 SHALL run an FSM with states CLEAR and RUN; ready = (state==RUN).
REQ-019 In CLEAR, SHALL zero one entry per cycle: counter runs 1..NREGS-1, then the FSM enters RUN; the sequence takes NREGS-1 cycles.
REQ-020 In RUN, clr_req=1 SHALL enter CLEAR on the next edge, reload the counter to 1 and clear all pending bits.
REQ-021 clr_req asserted in CLEAR SHALL be ignored; the sequence does not restart.
REQ-022 Register 0 SHALL never be stored: reads of index 0 return 0 and rs_pend=0; writes and allocs to index 0 are dropped.
REQ-023 Write: when we=1, ready=1 and rd!=0, mem[rd] SHALL update at the rising edge; writes while ready=0 are dropped.
REQ-024 Reads SHALL be combinational; when ready=0, every rdata lane SHALL be 0.
REQ-025 Bypass: if we=1, ready=1, rd==rs[i] and rd!=0, rdata[i] SHALL equal wdata in the same cycle.
REQ-026 Scoreboard: alloc_v=1 with ready=1 SHALL set pend[alloc_rd]; a qualifying write SHALL clear pend[rd] at the same edge.
REQ-027 If an alloc and a write target the same rd in the same cycle, alloc SHALL win and pend stays 1.
REQ-028 rs_pend[i] SHALL be pend[rs[i]] masked by a same-cycle qualifying write to rs[i], so a bypassed value reads as not pending.
REQ-029 tap SHALL register mem[TAP_IDX] with 1-cycle latency after the write edge, and SHALL read 0 through CLEAR.
REQ-030 If TAP_IDX=0 or TAP_IDX>=NREGS, tap SHALL be constant 0.
REQ-031 Multiple read ports SHALL read the same address independently; there are no port conflicts.

Reset
REQ-032 reset low SHALL asynchronously force state=CLEAR, counter=1, all pend=0 and tap=0; ready=0, rdata=0 and rs_pend=0 follow.
REQ-033 Storage contents are undefined during reset and become zero only through the CLEAR sequence.
REQ-034 Reset asserted mid-CLEAR or mid-RUN SHALL restart from the CLEAR start.
REQ-035 After reset release, the first write SHALL be accepted NREGS-1 cycles later.

Structure
REQ-036 A shared package SHALL hold the FSM state enum (CLEAR, RUN) and the defaults XLEN_DEF=32 and NREGS_DEF=32.
REQ-037 A single sub-module, rf_scoreboard, SHALL hold the pend vector, the alloc/write priority logic and the rs_pend masking.
REQ-038 The storage array SHALL have no reset, so it maps to distributed RAM; zeroing is done only by the FSM.

Verification
REQ-039 Reset release, NREGS=32 -> ready rises exactly 31 cycles later; all 31 registers read 0.
REQ-040 Write rd=5, 0xDEADBEEF with rs[0]=5 in the same cycle -> rdata[0]=0xDEADBEEF that cycle; rs[1]=5 on the next cycle also reads it.
REQ-041 Write rd=0, 0x1234, then read rs=0 -> 0; rs_pend=0.
REQ-042 alloc rd=7, then two idle cycles -> rs_pend=1 for rs=7; write rd=7 -> rs_pend=0 in that cycle; a simultaneous alloc and write to rd=7 -> pend stays 1.
REQ-043 Write rd=13, 0xA5 -> tap=0xA5 one cycle after the edge; clr_req -> tap=0, ready=0 for 31 cycles, and pend is cleared.
REQ-044 reset pulsed mid-CLEAR (cycle 10) -> the full 31-cycle sequence restarts; a write attempted during CLEAR is dropped (reads 0 afterwards).

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared types and defaults for the multi-port register file.
// FSM states and default widths live here.
package reg_file_mp_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-writeback scoreboard for the register file.
// Alloc beats writeback; a same-cycle write hides pending.
module rf_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   alloc_ok,
  input  logic [AW-1:0]          alloc_rd,
  input  logic                   wr_ok,
  input  logic [AW-1:0]          rd,
  input  logic [NRD-1:0][AW-1:0] rs,
  output logic [NRD-1:0]         rs_pend
);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nx;

  always_comb begin
    pend_nx = pend;
    if (wr_ok)
      pend_nx[rd] = 1'b0;
    if (alloc_ok)
      pend_nx[alloc_rd] = 1'b1;
    if (clr)
      pend_nx = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pend <= '0;
    else
      pend <= pend_nx;
  end

  // Entry 0 is never set, so rs==0 reads not pending.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rs_pend[i] = pend[rs[i]] &&
                   !(wr_ok && rd == rs[i]);
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with self-clearing
// sequence, pending scoreboard and a debug tap.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter  int XLEN    = XLEN_DEF,
  parameter  int NREGS   = NREGS_DEF,
  parameter  int NRD     = 2,
  parameter  int TAP_IDX = 13,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic                     we,
  input  logic [AW-1:0]            rd,
  input  logic [XLEN-1:0]          wdata,
  input  logic                     alloc_v,
  input  logic [AW-1:0]            alloc_rd,
  input  logic [NRD-1:0][AW-1:0]   rs,
  output logic [NRD-1:0][XLEN-1:0] rdata,
  output logic [NRD-1:0]           rs_pend,
  output logic [XLEN-1:0]          tap
);

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   cnt;
  logic            clr_en;
  logic            clr_last;
  logic            clr_go;
  logic            wr_ok;
  logic            alloc_ok;
  logic            wen;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wval;

  logic [XLEN-1:0] mem [1:NREGS-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= CLEAR;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (clr_last) state_nx = RUN;
      RUN:   if (clr_req)  state_nx = CLEAR;
      default: state_nx = CLEAR;
    endcase
  end

  always_comb begin
    ready    = (state == RUN);
    clr_en   = (state == CLEAR);
    clr_last = clr_en && (cnt == AW'(NREGS - 1));
    clr_go   = ready && clr_req;
    wr_ok    = ready && we && (rd != '0);
    alloc_ok = ready && alloc_v && (alloc_rd != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= AW'(1);
    else if (clr_go)
      cnt <= AW'(1);
    else if (clr_en && !clr_last)
      cnt <= cnt + AW'(1);
  end

  // Clear sequence and writes share one RAM write port.
  always_comb begin
    wen   = clr_en || wr_ok;
    waddr = clr_en ? cnt : rd;
    wval  = clr_en ? '0 : wdata;
  end

  always_ff @(posedge clk) begin
    if (wen)
      mem[waddr] <= wval;
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rdata[i] = '0;
      if (ready && rs[i] != '0)
        rdata[i] = (wr_ok && rd == rs[i]) ?
                   wdata : mem[rs[i]];
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_go),
    .alloc_ok (alloc_ok),
    .alloc_rd (alloc_rd),
    .wr_ok    (wr_ok),
    .rd       (rd),
    .rs       (rs),
    .rs_pend  (rs_pend)
  );

  generate
    if (TAP_IDX > 0 && TAP_IDX < NREGS) begin : g_tap
      localparam logic [AW-1:0] TA = AW'(TAP_IDX);
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          tap <= '0;
        else
          tap <= (ready && !clr_req) ? mem[TA] : '0;
      end
    end else begin : g_notap
      assign tap = '0;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed plus random bench for reg_file_mp against
// an array-based reference model.
module tb_reg_file_mp;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr_req;
  logic             ready;
  logic             we;
  logic [4:0]       rd;
  logic [31:0]      wdata;
  logic             alloc_v;
  logic [4:0]       alloc_rd;
  logic [1:0][4:0]  rs;
  logic [1:0][31:0] rdata;
  logic [1:0]       rs_pend;
  logic [31:0]      tap;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_m [32];
  bit   [31:0] pend_m;
  logic [31:0] tap_m;
  int          clr_left;

  reg_file_mp dut (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .ready    (ready),
    .we       (we),
    .rd       (rd),
    .wdata    (wdata),
    .alloc_v  (alloc_v),
    .alloc_rd (alloc_rd),
    .rs       (rs),
    .rdata    (rdata),
    .rs_pend  (rs_pend),
    .tap      (tap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mem_m[r] = '0;
    pend_m   = '0;
    tap_m    = '0;
    clr_left = 31;
  endtask

  function automatic logic m_ready();
    return reset && (clr_left == 0);
  endfunction

  function automatic logic [31:0] exp_rdata(int i);
    if (!m_ready() || rs[i] == 0) return '0;
    if (we && rd != 0 && rd == rs[i]) return wdata;
    return mem_m[rs[i]];
  endfunction

  function automatic logic exp_pend(int i);
    if (!m_ready() || rs[i] == 0) return 1'b0;
    if (we && rd == rs[i]) return 1'b0;
    return pend_m[rs[i]];
  endfunction

  task automatic check_outs(input string tag);
    #1;
    chk({tag, ".ready"}, 32'(ready), 32'(m_ready()));
    chk({tag, ".rdata0"}, rdata[0], exp_rdata(0));
    chk({tag, ".rdata1"}, rdata[1], exp_rdata(1));
    chk({tag, ".pend0"}, 32'(rs_pend[0]), 32'(exp_pend(0)));
    chk({tag, ".pend1"}, 32'(rs_pend[1]), 32'(exp_pend(1)));
    chk({tag, ".tap"}, tap, tap_m);
  endtask

  task automatic tick();
    if (!reset) begin
      model_reset();
    end else if (clr_left > 0) begin
      clr_left--;
      tap_m = '0;
    end else if (clr_req) begin
      model_reset();
    end else begin
      tap_m = mem_m[13];
      if (we && rd != 0) begin
        mem_m[rd]  = wdata;
        pend_m[rd] = 1'b0;
      end
      if (alloc_v && alloc_rd != 0)
        pend_m[alloc_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we      = 1'b0;
    alloc_v = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    rs[0] = 5'd3;
    rs[1] = 5'd13;
    check_outs("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    rd       = '0;
    wdata    = '0;
    alloc_rd = '0;
    rs       = '0;
    idle();
    do_reset();

    // Reset pulsed at cycle 10 of clear, with a dropped write
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin
        we = 1'b1; rd = 5'd9; wdata = 32'h1111_2222;
      end
      tick();
      idle();
      check_outs("clear1");
    end
    do_reset();
    for (int c = 1; c <= 31; c++) begin
      if (c == 8) begin
        we = 1'b1; rd = 5'd9; wdata = 32'h3333_4444;
      end
      tick();
      idle();
      if (c == 30) chk("ready_at_30", 32'(ready), 32'd0);
      if (c == 31) chk("ready_at_31", 32'(ready), 32'd1);
    end
    for (int r = 1; r < 32; r++) begin
      rs[0] = 5'(r);
      rs[1] = 5'(32 - r);
      check_outs("zeroed");
      chk("zero_reg", rdata[0], 32'd0);
    end

    // Bypass and follow-up read
    we = 1'b1; rd = 5'd5; wdata = 32'hDEAD_BEEF;
    rs[0] = 5'd5; rs[1] = 5'd0;
    check_outs("bypass");
    chk("bypass_val", rdata[0], 32'hDEAD_BEEF);
    tick();
    idle();
    rs[1] = 5'd5;
    check_outs("after_wr");
    chk("after_wr_val", rdata[1], 32'hDEAD_BEEF);

    // Writes to x0 dropped
    we = 1'b1; rd = 5'd0; wdata = 32'h1234;
    tick();
    idle();
    rs[0] = 5'd0; rs[1] = 5'd0;
    check_outs("x0");
    chk("x0_val", rdata[0], 32'd0);

    // Scoreboard
    alloc_v = 1'b1; alloc_rd = 5'd7;
    tick();
    idle();
    tick();
    tick();
    rs[0] = 5'd7; rs[1] = 5'd7;
    check_outs("pend_set");
    chk("pend_set_v", 32'(rs_pend[0]), 32'd1);
    we = 1'b1; rd = 5'd7; wdata = 32'h77;
    check_outs("pend_wb");
    chk("pend_wb_v", 32'(rs_pend[0]), 32'd0);
    tick();
    idle();
    check_outs("pend_clr");
    chk("pend_clr_v", 32'(rs_pend[1]), 32'd0);
    alloc_v = 1'b1; alloc_rd = 5'd7;
    we = 1'b1; rd = 5'd7; wdata = 32'h78;
    tick();
    idle();
    check_outs("alloc_win");
    chk("alloc_win_v", 32'(rs_pend[0]), 32'd1);

    // Tap and soft clear
    we = 1'b1; rd = 5'd13; wdata = 32'hA5;
    tick();
    idle();
    check_outs("tap_lat");
    tick();
    check_outs("tap_val");
    chk("tap_a5", tap, 32'hA5);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check_outs("soft_clr");
    chk("soft_clr_tap", tap, 32'd0);
    for (int c = 1; c <= 31; c++) begin
      if (c == 4) clr_req = 1'b1;
      tick();
      idle();
      check_outs("soft_seq");
      if (c == 30) chk("soft_rdy30", 32'(ready), 32'd0);
    end
    chk("soft_rdy31", 32'(ready), 32'd1);
    rs[0] = 5'd7; rs[1] = 5'd13;
    check_outs("soft_done");
    chk("soft_pend", 32'(rs_pend[0]), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      we       = 1'($urandom_range(0, 1));
      rd       = 5'($urandom_range(0, 31));
      wdata    = $urandom;
      alloc_v  = ($urandom_range(0, 2) == 0);
      alloc_rd = ($urandom_range(0, 3) == 0) ?
                 rd : 5'($urandom_range(0, 31));
      rs[0]    = ($urandom_range(0, 3) == 0) ?
                 rd : 5'($urandom_range(0, 31));
      rs[1]    = ($urandom_range(0, 5) == 0) ?
                 5'd13 : 5'($urandom_range(0, 31));
      clr_req  = ($urandom_range(0, 99) == 0);
      check_outs("rand");
      tick();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
